apb_decoder: RTL and testbench
==============================

APB_DECODER -- requirements
Module: apb_decoder

Interface
REQ-001 The block SHALL have parameter ADDR_TDR, default 8'h00, meaning the TDR address.
REQ-002 The block SHALL have parameter ADDR_TCR, default 8'h01, meaning the TCR address.
REQ-003 The block SHALL have parameter ADDR_TSR, default 8'h02, meaning the TSR address.
REQ-004 The block SHALL have the port pclk, input, 1 bit: the single clock, with all logic on the rising edge.
REQ-005 The block SHALL have the port presetn, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have the APB input ports psel, penable and pwrite, each 1 bit: the APB control signals.
REQ-007 The block SHALL have the port paddr, input, 8 bits: the register address.
REQ-008 The block SHALL have the port pwdata, input, 8 bits: the write data.
REQ-009 The block SHALL have the port ovf_set, input, 1 bit: counter overflow event, a one-cycle pulse.
REQ-010 The block SHALL have the port udf_set, input, 1 bit: counter underflow event, a one-cycle pulse.
REQ-011 The block SHALL have the port pready, output, 1 bit: transfer-complete handshake.
REQ-012 The block SHALL have the port pslverr, output, 1 bit: error on an unmapped address.
REQ-013 The block SHALL have the port select_reg, output, 3 bits: one-hot read select, 001=TDR, 010=TCR, 100=TSR, 000=none.
REQ-014 The block SHALL have the ports tdr, tcr and tsr, outputs, 8 bits each: register contents.
REQ-015 The block SHALL have the port tdr_load, output, 1 bit: one-cycle pulse requesting a counter load from TDR.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, WAIT and READY, registered on pclk.
REQ-017 IDLE->SETUP SHALL occur on psel & ~penable; IDLE otherwise holds.
REQ-018 SETUP->WAIT SHALL occur on psel & penable; SETUP->IDLE SHALL occur if psel drops.
REQ-019 WAIT->READY SHALL occur unconditionally: exactly one wait state.
REQ-020 READY->SETUP SHALL occur on psel & ~penable (back-to-back); READY->IDLE otherwise.
REQ-021 pready SHALL be 1 only in READY, giving an access phase of 2 cycles.
REQ-022 select_reg SHALL be decoded combinationally from paddr whenever psel=1, and SHALL be 000 when psel=0 or paddr is unmapped.
REQ-023 pslverr SHALL be 1 only in READY when paddr is unmapped, for both reads and writes.
REQ-024 A write SHALL commit at the pclk edge ending READY when pwrite=1; no register changes on reads, in WAIT, or on an error transfer.
REQ-025 A TDR write SHALL set tdr to pwdata.
REQ-026 A TCR write SHALL set tcr[6:0] to pwdata[6:0]; tcr[7] (load) SHALL be set to pwdata[7] and SHALL clear by itself on the next cycle.
REQ-027 tdr_load SHALL equal tcr[7], so it is high for exactly one cycle per write of 1.
REQ-028 tsr[0] (OVF) SHALL be set by ovf_set, and tsr[1] (UDF) SHALL be set by udf_set.
REQ-029 Both TSR flags SHALL be cleared by writing 1 to the bit (W1C); writing 0 SHALL have no effect.
REQ-030 When a set event and a W1C clear hit the same bit in the same cycle, the set SHALL win.
REQ-031 tsr[7:2] SHALL read 0, and writes to those bits SHALL be ignored.
REQ-032 paddr/pwdata changes during WAIT SHALL be ignored in favour of the values present at the commit edge, since APB holds them stable.
REQ-033 If psel drops mid-transfer (WAIT/READY), the FSM SHALL return to IDLE with no commit.

Reset
REQ-034 While presetn=0 at a pclk edge, the block SHALL set FSM=IDLE, tdr=8'h00, tcr=8'h00, tsr=8'h00, pready=0, pslverr=0 and tdr_load=0.
REQ-035 Reset SHALL take priority over every write and every set event, including a write in READY.
REQ-036 No asynchronous path from presetn SHALL exist.

Structure
REQ-037 A shared package timer_pkg SHALL hold the address constants, the FSM state encoding (2-bit enum), the one-hot select codes and the TSR/TCR bit positions, for reuse by the read mux and the counter.
REQ-038 One sub-module, w1c_bit (a single set/W1C flag with set priority), SHALL be instantiated twice for OVF and UDF.

Verification
REQ-039 Write 8'hA5 to 0x00 -> pready=0 in WAIT and 1 in the next cycle; tdr=8'hA5 after READY; pslverr=0.
REQ-040 Write 8'h93 to 0x01 -> tcr=8'h93 for one cycle, then 8'h13; tdr_load high for exactly one cycle.
REQ-041 Pulse ovf_set, then write 8'h01 to 0x02 -> tsr goes 8'h01 then 8'h00. A repeat where ovf_set coincides with the commit edge -> tsr stays 8'h01.
REQ-042 Write 8'hFF to 0x05 -> select_reg=000; pslverr=1 in READY; tdr/tcr/tsr unchanged.
REQ-043 Read of 0x02 -> select_reg=100 for SETUP/WAIT/READY; no register change; pready timing as for writes.
REQ-044 Assert presetn=0 in READY of a TDR write of 8'h3C -> tdr=8'h00 next cycle; FSM IDLE; pready=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the timer register block: default register addresses,
// APB FSM state encoding, one-hot read-select codes, register bit positions
// and the address decode helper.
package timer_pkg;

    localparam logic [7:0] ADDR_TDR_DFLT = 8'h00;
    localparam logic [7:0] ADDR_TCR_DFLT = 8'h01;
    localparam logic [7:0] ADDR_TSR_DFLT = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2,
        ST_READY = 2'd3
    } apb_state_e;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_TDR  = 3'b001;
    localparam logic [2:0] SEL_TCR  = 3'b010;
    localparam logic [2:0] SEL_TSR  = 3'b100;

    localparam int TSR_OVF_BIT  = 0;
    localparam int TSR_UDF_BIT  = 1;
    localparam int TCR_LOAD_BIT = 7;

    // Map an address onto the one-hot register select; unmapped gives SEL_NONE.
    function automatic logic [2:0] f_decode(
        input logic [7:0] addr,
        input logic [7:0] a_tdr,
        input logic [7:0] a_tcr,
        input logic [7:0] a_tsr
    );
        logic [2:0] sel;
        if (addr == a_tdr) begin
            sel = SEL_TDR;
        end else if (addr == a_tcr) begin
            sel = SEL_TCR;
        end else if (addr == a_tsr) begin
            sel = SEL_TSR;
        end else begin
            sel = SEL_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/w1c_bit.sv
// Single sticky status flag: set by a hardware event, cleared by a
// write-one-to-clear; a set in the same cycle as a clear wins.
module w1c_bit
    import timer_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_set,
    input  logic i_clr,
    output logic o_q
);

    logic r_q;

    // Flag storage with synchronous reset and set-over-clear priority.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q <= 1'b0;
        end else if (i_set) begin
            r_q <= 1'b1;
        end else if (i_clr) begin
            r_q <= 1'b0;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/apb_decoder.sv
// APB slave front end for the timer registers TDR/TCR/TSR. Every transfer
// carries exactly one wait state; writes commit at the edge that ends READY.
module apb_decoder
    import timer_pkg::*;
#(
    parameter logic [7:0] ADDR_TDR = ADDR_TDR_DFLT,
    parameter logic [7:0] ADDR_TCR = ADDR_TCR_DFLT,
    parameter logic [7:0] ADDR_TSR = ADDR_TSR_DFLT
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    input  logic       ovf_set,
    input  logic       udf_set,
    output logic       pready,
    output logic       pslverr,
    output logic [2:0] select_reg,
    output logic [7:0] tdr,
    output logic [7:0] tcr,
    output logic [7:0] tsr,
    output logic       tdr_load
);

    apb_state_e r_state;
    logic       r_pready;
    logic       r_pslverr;
    logic [7:0] r_tdr;
    logic [7:0] r_tcr;

    logic [2:0] w_addr_sel;
    logic [2:0] w_sel;
    logic       w_unmapped;
    logic       w_commit;
    logic       w_wr_tdr;
    logic       w_wr_tcr;
    logic       w_wr_tsr;
    logic       w_ovf;
    logic       w_udf;
    logic [7:0] w_tsr;

    // Address decode, gated by psel for the read-select output.
    always_comb begin
        w_addr_sel = f_decode(paddr, ADDR_TDR, ADDR_TCR, ADDR_TSR);
        w_unmapped = (w_addr_sel == SEL_NONE);
        if (psel) begin
            w_sel = w_addr_sel;
        end else begin
            w_sel = SEL_NONE;
        end
    end

    // Write strobes: only a live, mapped write in READY commits.
    always_comb begin
        w_commit = (r_state == ST_READY) && psel && penable && pwrite && !w_unmapped;
        w_wr_tdr = w_commit && (w_addr_sel == SEL_TDR);
        w_wr_tcr = w_commit && (w_addr_sel == SEL_TCR);
        w_wr_tsr = w_commit && (w_addr_sel == SEL_TSR);
    end

    // APB handshake FSM with registered pready/pslverr.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state   <= ST_IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    if (psel && !penable) begin
                        r_state <= ST_SETUP;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    if (!psel) begin
                        r_state <= ST_IDLE;
                    end else if (penable) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_state <= ST_SETUP;
                    end
                end
                ST_WAIT: begin
                    // The single wait state; an abandoned transfer goes idle.
                    if (psel) begin
                        r_state   <= ST_READY;
                        r_pready  <= 1'b1;
                        r_pslverr <= w_unmapped;
                    end else begin
                        r_state   <= ST_IDLE;
                        r_pready  <= 1'b0;
                        r_pslverr <= 1'b0;
                    end
                end
                ST_READY: begin
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    if (psel && !penable) begin
                        r_state <= ST_SETUP;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                end
            endcase
        end
    end

    // TDR and TCR storage; the TCR load bit is a one-cycle strobe.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_tdr <= 8'h00;
            r_tcr <= 8'h00;
        end else begin
            if (w_wr_tdr) begin
                r_tdr <= pwdata;
            end else begin
                r_tdr <= r_tdr;
            end
            if (w_wr_tcr) begin
                r_tcr <= pwdata;
            end else begin
                r_tcr               <= r_tcr;
                r_tcr[TCR_LOAD_BIT] <= 1'b0;
            end
        end
    end

    w1c_bit u_ovf (
        .i_clk   (pclk),
        .i_rst_n (presetn),
        .i_set   (ovf_set),
        .i_clr   (w_wr_tsr && pwdata[TSR_OVF_BIT]),
        .o_q     (w_ovf)
    );

    w1c_bit u_udf (
        .i_clk   (pclk),
        .i_rst_n (presetn),
        .i_set   (udf_set),
        .i_clr   (w_wr_tsr && pwdata[TSR_UDF_BIT]),
        .o_q     (w_udf)
    );

    // Assemble TSR; the upper bits are reserved and read as zero.
    always_comb begin
        w_tsr              = 8'h00;
        w_tsr[TSR_OVF_BIT] = w_ovf;
        w_tsr[TSR_UDF_BIT] = w_udf;
    end

    assign pready     = r_pready;
    assign pslverr    = r_pslverr;
    assign select_reg = w_sel;
    assign tdr        = r_tdr;
    assign tcr        = r_tcr;
    assign tsr        = w_tsr;
    assign tdr_load   = r_tcr[TCR_LOAD_BIT];

endmodule

// File: tb/tb_apb_decoder.sv
// Bench for apb_decoder: directed transfers followed by random ones, all
// checked against a register-level model of the timer block.
module tb_apb_decoder;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic       ovf_set;
    logic       udf_set;
    logic       pready;
    logic       pslverr;
    logic [2:0] select_reg;
    logic [7:0] tdr;
    logic [7:0] tcr;
    logic [7:0] tsr;
    logic       tdr_load;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_tdr;
    logic [7:0] m_tcr;
    logic       m_ovf;
    logic       m_udf;

    always #5 pclk = ~pclk;

    apb_decoder #(
        .ADDR_TDR (8'h00),
        .ADDR_TCR (8'h01),
        .ADDR_TSR (8'h02)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .ovf_set    (ovf_set),
        .udf_set    (udf_set),
        .pready     (pready),
        .pslverr    (pslverr),
        .select_reg (select_reg),
        .tdr        (tdr),
        .tcr        (tcr),
        .tsr        (tsr),
        .tdr_load   (tdr_load)
    );

    function automatic logic [2:0] exp_sel(input logic s, input logic [7:0] a);
        if (!s) return 3'b000;
        if (a == 8'h00) return 3'b001;
        if (a == 8'h01) return 3'b010;
        if (a == 8'h02) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic mapped(input logic [7:0] a);
        return (a == 8'h00) || (a == 8'h01) || (a == 8'h02);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".tdr"}, {24'd0, tdr}, {24'd0, m_tdr});
        chk({tag, ".tcr"}, {24'd0, tcr}, {24'd0, m_tcr});
        chk({tag, ".tsr"}, {24'd0, tsr}, {24'd0, 6'd0, m_udf, m_ovf});
        chk({tag, ".load"}, {31'd0, tdr_load}, {31'd0, m_tcr[7]});
    endtask

    // Advance to just after the next rising edge (the drive point).
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Full APB transfer with optional event pulses or reset at the commit edge.
    task automatic xfer(input logic [7:0] a, input logic [7:0] d, input logic wr,
                        input logic so, input logic su, input logic rst_rdy);
        psel = 1'b1; penable = 1'b0; paddr = a; pwdata = d; pwrite = wr;
        @(negedge pclk);
        chk("setup.sel", {29'd0, select_reg}, {29'd0, exp_sel(1'b1, a)});
        chk("setup.rdy", {31'd0, pready}, 32'd0);
        step();
        penable = 1'b1;
        @(negedge pclk);
        chk("access.sel", {29'd0, select_reg}, {29'd0, exp_sel(1'b1, a)});
        chk("access.rdy", {31'd0, pready}, 32'd0);
        step();
        @(negedge pclk);
        chk("wait.rdy", {31'd0, pready}, 32'd0);
        chk("wait.err", {31'd0, pslverr}, 32'd0);
        step();
        ovf_set = so; udf_set = su;
        if (rst_rdy) presetn = 1'b0;
        @(negedge pclk);
        chk("ready.rdy", {31'd0, pready}, 32'd1);
        chk("ready.err", {31'd0, pslverr}, {31'd0, !mapped(a)});
        chk("ready.sel", {29'd0, select_reg}, {29'd0, exp_sel(1'b1, a)});
        step();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        ovf_set = 1'b0; udf_set = 1'b0; presetn = 1'b1;
        if (rst_rdy) begin
            m_tdr = 8'h00; m_tcr = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            if (wr && a == 8'h02) begin
                m_ovf = m_ovf & ~d[0];
                m_udf = m_udf & ~d[1];
            end
            if (wr && a == 8'h00) m_tdr = d;
            if (wr && a == 8'h01) m_tcr = d;
            m_ovf = m_ovf | so;
            m_udf = m_udf | su;
        end
        @(negedge pclk);
        chk_regs("post");
        chk("post.rdy", {31'd0, pready}, 32'd0);
        chk("post.err", {31'd0, pslverr}, 32'd0);
        chk("post.sel", {29'd0, select_reg}, 32'd0);
        step();
        m_tcr[7] = 1'b0;
        @(negedge pclk);
        chk_regs("idle");
        chk("idle.rdy", {31'd0, pready}, 32'd0);
        step();
    endtask

    // Standalone event pulse outside any transfer.
    task automatic pulse(input logic so, input logic su);
        ovf_set = so; udf_set = su;
        step();
        ovf_set = 1'b0; udf_set = 1'b0;
        m_ovf = m_ovf | so;
        m_udf = m_udf | su;
        @(negedge pclk);
        chk_regs("pulse");
        step();
    endtask

    initial begin
        logic [7:0] a;
        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00; ovf_set = 1'b0; udf_set = 1'b0;
        m_tdr = 8'h00; m_tcr = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
        step();
        step();
        @(negedge pclk);
        chk_regs("reset");
        chk("reset.rdy", {31'd0, pready}, 32'd0);
        chk("reset.err", {31'd0, pslverr}, 32'd0);
        chk("reset.sel", {29'd0, select_reg}, 32'd0);
        step();
        presetn = 1'b1;
        step();

        // Directed scenarios
        xfer(8'h00, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        xfer(8'h01, 8'h93, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        xfer(8'h02, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        xfer(8'h02, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1);
        xfer(8'h02, 8'hFC, 1'b1, 1'b0, 1'b0, 1'b0);
        xfer(8'h02, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        xfer(8'h05, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        xfer(8'h02, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'h00, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
        xfer(8'h00, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

        // Transfer abandoned in WAIT: nothing commits
        psel = 1'b1; penable = 1'b0; paddr = 8'h00; pwdata = 8'h77; pwrite = 1'b1;
        step();
        penable = 1'b1;
        step();
        psel = 1'b0; penable = 1'b0;
        step();
        @(negedge pclk);
        chk("abort.rdy", {31'd0, pready}, 32'd0);
        chk_regs("abort");
        step();
        step();
        @(negedge pclk);
        chk("abort2.rdy", {31'd0, pready}, 32'd0);
        chk_regs("abort2");
        step();

        // Randomized transfers
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: a = 8'h00;
                1: a = 8'h01;
                2: a = 8'h02;
                3: a = 8'h05;
                default: a = 8'($urandom_range(3, 255));
            endcase
            if ($urandom_range(0, 3) == 0) pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            xfer(a, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
